// File: rtl/regbank_pkg.sv
// rtl/regbank_pkg.sv - shared types and helpers for the register-bank write-enable sequencer
// Contents: FSM state encoding, default address width, one-hot helper.
package regbank_pkg;

  localparam int DEFAULT_ADDR_W = 4;
  localparam int DEFAULT_DEPTH  = 2 ** DEFAULT_ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  // One-hot expansion of an address at the default bank size.
  function automatic logic [DEFAULT_DEPTH-1:0] onehot(input logic [DEFAULT_ADDR_W-1:0] addr);
    logic [DEFAULT_DEPTH-1:0] v;
    v       = '0;
    v[addr] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/regbank_we_sequencer_if.sv
// rtl/regbank_we_sequencer_if.sv - request/enable bundle between requester and enable sequencer
// Signals:
//   wr_valid, wr_addr   requester -> sequencer  write request
//   wr_ready            sequencer -> requester  request accepted this cycle
//   clr_req             requester -> sequencer  start bulk clear
//   err_clr             requester -> sequencer  clear sticky protection error
//   en_out              sequencer -> bank       one-hot write enable (registered)
//   clr_sel             sequencer -> bank       select zero write data (registered)
//   busy                sequencer -> requester  sweep in progress (registered)
//   prot_err            sequencer -> requester  sticky protected-write error
import regbank_pkg::*;

interface regbank_we_sequencer_if #(
  parameter int ADDR_W = DEFAULT_ADDR_W
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_ready;
  logic              clr_req;
  logic              err_clr;
  logic [DEPTH-1:0]  en_out;
  logic              clr_sel;
  logic              busy;
  logic              prot_err;

  modport master (
    output wr_valid, wr_addr, clr_req, err_clr,
    input  wr_ready, en_out, clr_sel, busy, prot_err
  );

  modport slave (
    input  wr_valid, wr_addr, clr_req, err_clr,
    output wr_ready, en_out, clr_sel, busy, prot_err
  );

endinterface

// File: rtl/regbank_onehot_dec.sv
// rtl/regbank_onehot_dec.sv - combinational address-to-one-hot decoder with protect-mask gate
// Ports:
//   addr  in   ADDR_W  register index to decode
//   en    out  DEPTH   one-hot enable, zero when addr is protected
//   prot  out  1       addr is a protected register
import regbank_pkg::*;

module regbank_onehot_dec #(
  parameter int                    ADDR_W       = DEFAULT_ADDR_W,
  parameter logic [2**ADDR_W-1:0]  PROTECT_MASK = '0
) (
  input  logic [ADDR_W-1:0]   addr,
  output logic [2**ADDR_W-1:0] en,
  output logic                prot
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] raw;

  always_comb begin
    raw       = '0;
    raw[addr] = 1'b1;
  end

  assign prot = PROTECT_MASK[addr];
  assign en   = raw & ~PROTECT_MASK;

endmodule

// File: rtl/regbank_we_sequencer.sv
// rtl/regbank_we_sequencer.sv - write-enable generator with write protection and bulk-clear sweep
// Ports:
//   clk  in   system clock, rising edge
//   rst  in   synchronous active-high reset
//   bus  slave modport of regbank_we_sequencer_if (request, enable, status signals)
import regbank_pkg::*;

module regbank_we_sequencer #(
  parameter int                   ADDR_W       = DEFAULT_ADDR_W,
  parameter logic [2**ADDR_W-1:0] PROTECT_MASK = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  regbank_we_sequencer_if.slave  bus
);

  localparam int                DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] cnt;        // index whose enable is currently on en_q
  logic [DEPTH-1:0]  en_q;
  logic              clr_sel_q;
  logic              busy_q;
  logic              prot_err_q;

  logic [ADDR_W-1:0] cnt_next;
  logic [ADDR_W-1:0] dec_addr;
  logic [DEPTH-1:0]  dec_en;
  logic              dec_prot;
  logic              wr_ready_c;

  assign cnt_next   = cnt + ADDR_W'(1);
  assign wr_ready_c = (state == IDLE) && !bus.clr_req;

  // The single decoder serves both paths: the requested address in IDLE,
  // and the sweep index (entry 0 on the start edge, then the next index)
  // so that en_out, clr_sel and busy line up cycle for cycle.
  always_comb begin
    dec_addr = bus.wr_addr;
    if (state == SWEEP)
      dec_addr = cnt_next;
    else if (bus.clr_req)
      dec_addr = '0;
  end

  regbank_onehot_dec #(
    .ADDR_W       (ADDR_W),
    .PROTECT_MASK (PROTECT_MASK)
  ) u_dec (
    .addr (dec_addr),
    .en   (dec_en),
    .prot (dec_prot)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      en_q       <= '0;
      clr_sel_q  <= 1'b0;
      busy_q     <= 1'b0;
      prot_err_q <= 1'b0;
    end else begin
      en_q      <= '0;
      clr_sel_q <= 1'b0;

      // Clear first so a same-cycle protected write below overrides it.
      if (bus.err_clr)
        prot_err_q <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.clr_req) begin
            state     <= SWEEP;
            cnt       <= '0;
            busy_q    <= 1'b1;
            clr_sel_q <= 1'b1;
            en_q      <= dec_en;
          end else if (bus.wr_valid) begin
            en_q <= dec_en;
            if (dec_prot)
              prot_err_q <= 1'b1;
          end
        end

        SWEEP: begin
          if (cnt == LAST) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
          end else begin
            cnt       <= cnt_next;
            clr_sel_q <= 1'b1;
            en_q      <= dec_en;
          end
        end

        default: begin
          state  <= IDLE;
          cnt    <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wr_ready = wr_ready_c;
  assign bus.en_out   = en_q;
  assign bus.clr_sel  = clr_sel_q;
  assign bus.busy     = busy_q;
  assign bus.prot_err = prot_err_q;

endmodule

// File: tb/tb_regbank_we_sequencer.sv
// tb/tb_regbank_we_sequencer.sv - directed self-checking bench for regbank_we_sequencer
module tb_regbank_we_sequencer;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  regbank_we_sequencer_if #(.ADDR_W(4)) bus ();

  regbank_we_sequencer #(
    .ADDR_W       (4),
    .PROTECT_MASK (16'h0001)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] sweep_exp [16];
  int          guard;

  initial begin
    errors = 0;
    checks = 0;
    sweep_exp = '{16'h0000, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020, 16'h0040, 16'h0080,
                  16'h0100, 16'h0200, 16'h0400, 16'h0800, 16'h1000, 16'h2000, 16'h4000, 16'h8000};

    // Reset with a pending write that must be ignored.
    rst          = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 4'd5;
    bus.clr_req  = 1'b0;
    bus.err_clr  = 1'b0;
    step();
    step();
    check("rst_en_out", 32'(bus.en_out), 32'h0000);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_prot_err", 32'(bus.prot_err), 32'd0);
    check("rst_clr_sel", 32'(bus.clr_sel), 32'd0);
    rst          = 1'b0;
    bus.wr_valid = 1'b0;
    #1;
    check("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
    step();
    check("idle_en_out", 32'(bus.en_out), 32'h0000);

    // Single write.
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 4'hA;
    step();
    bus.wr_valid = 1'b0;
    check("single_en", 32'(bus.en_out), 32'h0400);
    check("single_clr_sel", 32'(bus.clr_sel), 32'd0);
    step();
    check("single_pulse_end", 32'(bus.en_out), 32'h0000);

    // Streaming back-to-back writes.
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 4'd3;
    step();
    check("stream_0", 32'(bus.en_out), 32'h0008);
    bus.wr_addr  = 4'd15;
    step();
    check("stream_1", 32'(bus.en_out), 32'h8000);
    bus.wr_addr  = 4'd7;
    step();
    check("stream_2", 32'(bus.en_out), 32'h0080);
    bus.wr_valid = 1'b0;
    step();
    check("stream_end", 32'(bus.en_out), 32'h0000);

    // Protected register write.
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 4'd0;
    step();
    bus.wr_valid = 1'b0;
    check("prot_en_out", 32'(bus.en_out), 32'h0000);
    check("prot_err_set", 32'(bus.prot_err), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("prot_err_sticky", 32'(bus.prot_err), 32'd1);
    end
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    check("prot_err_cleared", 32'(bus.prot_err), 32'd0);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 4'd0;
    bus.err_clr  = 1'b1;
    step();
    bus.wr_valid = 1'b0;
    bus.err_clr  = 1'b0;
    check("prot_set_wins", 32'(bus.prot_err), 32'd1);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    check("prot_err_cleared2", 32'(bus.prot_err), 32'd0);

    // Sweep, with a competing write on the start cycle.
    bus.clr_req  = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 4'd2;
    #1;
    check("sweep_start_wr_ready", 32'(bus.wr_ready), 32'd0);
    step();
    bus.clr_req  = 1'b0;
    bus.wr_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("sweep_en_out", 32'(bus.en_out), 32'(sweep_exp[i]));
      check("sweep_busy", 32'(bus.busy), 32'd1);
      check("sweep_clr_sel", 32'(bus.clr_sel), 32'd1);
      if (i == 5) begin
        bus.clr_req  = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 4'd9;
        #1;
        check("sweep_wr_ready", 32'(bus.wr_ready), 32'd0);
      end
      step();
      bus.clr_req  = 1'b0;
      bus.wr_valid = 1'b0;
    end
    check("sweep_done_busy", 32'(bus.busy), 32'd0);
    check("sweep_done_clr_sel", 32'(bus.clr_sel), 32'd0);
    check("sweep_done_en_out", 32'(bus.en_out), 32'h0000);
    check("sweep_done_wr_ready", 32'(bus.wr_ready), 32'd1);
    check("sweep_no_prot_err", 32'(bus.prot_err), 32'd0);
    step();
    check("sweep_no_restart", 32'(bus.busy), 32'd0);

    // Reset in the middle of a sweep.
    bus.clr_req = 1'b1;
    step();
    bus.clr_req = 1'b0;
    guard = 0;
    while (bus.en_out !== 16'h0040 && guard < 20) begin
      step();
      guard++;
    end
    check("midrst_reach_0040", 32'(bus.en_out), 32'h0040);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_en_out", 32'(bus.en_out), 32'h0000);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    step();
    check("midrst_no_more_en", 32'(bus.en_out), 32'h0000);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 4'd9;
    step();
    bus.wr_valid = 1'b0;
    check("midrst_write9", 32'(bus.en_out), 32'h0200);
    check("midrst_write9_clr_sel", 32'(bus.clr_sel), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
